float_add_issuer: RTL and testbench
===================================

# float_add_issuer

Front-end sequencer for `pipelined_float_adder`. It buffers float32 operand pairs from a valid/ready host port and issues them into the adder's input handshake. It collects the adder's results in issue order and presents them on a valid/ready output port. A credit scheme reserves a result slot for every operation in flight, so results are never dropped and the adder never needs back-pressure.

## Interface
- `DEPTH`, 4: depth of the operand FIFO and of the result FIFO. Power of two, ≥2. Also the maximum number of credits.
- `clk_i` in 1: clock, rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `s_valid_i` in 1: host offers an operand pair.
- `s_ready_o` out 1: operand FIFO not full.
- `s_a_i` in 32: operand A, IEEE-754 single.
- `s_b_i` in 32: operand B, IEEE-754 single.
- `add_req_o` out 1: issue request; drives the adder's `inp_rdy`.
- `add_a_o` out 32: head operand A; drives `in_a`.
- `add_b_o` out 32: head operand B; drives `in_b`.
- `add_ack_i` in 1: adder input stage free; driven from `stage_status[0]`.
- `add_res_valid_i` in 1: one-cycle pulse per completed sum.
- `add_res_i` in 32: sum; sampled when `add_res_valid_i` = 1.
- `m_valid_o` out 1: result available.
- `m_ready_i` in 1: host accepts the result.
- `m_sum_o` out 32: head result.
- `inflight_o` out $clog2(DEPTH)+1: number of operations issued but not yet returned.
- `error_o` out 1: sticky flag for a spurious or overflowing result.

## Operation
- **Host push.** A push occurs on an edge with `s_valid_i && s_ready_o`. `s_ready_o = !op_full`, derived from registered state.
- **Credits.** `credits = DEPTH - inflight - res_count`. Issue is allowed only when `credits > 0`.
- **Issue request.** `add_req_o = !op_empty && credits > 0`, combinational from registered state. `add_a_o`/`add_b_o` always show the operand FIFO head. They are 0 when the FIFO is empty.
- **Issue.** An issue occurs on an edge with `add_req_o && add_ack_i`: pop the operand FIFO and increment `inflight`.
- **Result return.** On an edge with `add_res_valid_i`:
  - If `inflight == 0` or the result FIFO is full, drop the result and set `error_o`.
  - Otherwise push `add_res_i` and decrement `inflight`.
- **Simultaneous issue and return.** `inflight` is unchanged.
- **Host pop.** A pop occurs on an edge with `m_valid_o && m_ready_i`. `m_valid_o = !res_empty`.
- **Simultaneous push and pop.** Both FIFOs allow push and pop on the same edge, including when full (result FIFO) or empty (push only). Counts stay consistent.
- **Ordering.** Results leave in issue order. The adder is in-order, so no tags are used.
- **Pointer width.** FIFO pointers are `$clog2(DEPTH)` bits and wrap naturally. Fill counts are one bit wider.
- **`error_o`** is cleared only by `rst_i`.

## Timing
- **Reset values.** While `rst_i` is high, immediately and asynchronously:
  - Both FIFOs empty, `inflight_o` = 0, `error_o` = 0.
  - Hence `s_ready_o` = 1, `add_req_o` = 0, `m_valid_o` = 0, `add_a_o`/`add_b_o`/`m_sum_o` = 0.
- **Reset mid-operation.** Queued operands and results are discarded. The adder shares `rst_i`, so no stale result returns.
- **Latencies.**
  - Host push at edge N → `add_req_o` high after edge N (visible in cycle N+1). There is no bypass.
  - Result pulse at edge M → `m_valid_o` high in cycle M+1.
- **Stalled issue.** While `add_req_o` is high and `add_ack_i` is low, `add_a_o`/`add_b_o` hold stable.
- **No combinational ready/valid paths.** `s_ready_o` does not depend on `s_valid_i`, and `m_valid_o` does not depend on `m_ready_i`.

## Structure
- **Package `float_add_pkg`:**
  - `float32_t` packed struct: `sign`, `exponent[7:0]`, `mantissa[22:0]`.
  - `FA_DEFAULT_DEPTH` = 4.
  - `FA_PIPE_LATENCY` = 5, used by the bench stub.
- **Sub-module `sync_fifo`:** parameterised `WIDTH`/`DEPTH`, async active-high reset, exposes a `count` output.
  - Instantiated twice: operands at WIDTH 64, results at WIDTH 32.
  - Top level holds the credit and `inflight` counters, the error flag, and the glue logic.

## Test plan
- **Single operation.** Push A=0x3F800000, B=0x40000000. Adder stub has ack=1 and returns 0x40400000 five cycles later → `m_sum_o`=0x40400000, `m_valid_o` for one cycle with `m_ready_i`=1, `inflight_o` returns to 0.
- **Back-pressure.** DEPTH=4, `m_ready_i`=0, push 10 pairs.
  - Exactly 4 issues occur, then `add_req_o` stays 0.
  - `s_ready_o` drops after 8 accepted pairs.
  - Releasing `m_ready_i` drains 10 results in order.
- **Issue stall.** `add_ack_i`=0 for 6 cycles with the operand FIFO non-empty → `add_req_o`=1 and `add_a_o`/`add_b_o` stable throughout. The first ack pops exactly one entry.
- **Ordering and streaming.** Pushes and pops both continuous. Stub returns sums 0x41200000, 0xC0A00000, 0x00000000 → output in the same order, no bubbles at steady state, `error_o`=0.
- **Spurious result.** `add_res_valid_i` pulse with `inflight_o`=0 → `error_o`=1 (sticky), `m_valid_o` remains 0.
- **Reset mid-flight.** `rst_i` asserted between edges with 3 operations in flight → all outputs reach their reset values before the next edge. After release, a normal operation completes correctly.

Source files
------------

// File: rtl/float_add_pkg.sv
// Shared types and constants for the float adder front-end sequencer.
package float_add_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exponent;
    logic [22:0] mantissa;
  } float32_t;

  // Operand A occupies the upper half of the packed pair.
  typedef struct packed {
    float32_t a;
    float32_t b;
  } operand_pair_t;

  localparam int unsigned FA_DEFAULT_DEPTH = 4;
  localparam int unsigned FA_PIPE_LATENCY  = 5;

endpackage

// File: rtl/float_add_issuer_if.sv
// Host and adder handshake bundle for float_add_issuer; slave is the issuer side.
interface float_add_issuer_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          s_valid_i;
  logic          s_ready_o;
  logic [31:0]   s_a_i;
  logic [31:0]   s_b_i;
  logic          add_req_o;
  logic [31:0]   add_a_o;
  logic [31:0]   add_b_o;
  logic          add_ack_i;
  logic          add_res_valid_i;
  logic [31:0]   add_res_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [31:0]   m_sum_o;
  logic [CW-1:0] inflight_o;
  logic          error_o;

  modport slave (
    input  s_valid_i, s_a_i, s_b_i, add_ack_i, add_res_valid_i, add_res_i, m_ready_i,
    output s_ready_o, add_req_o, add_a_o, add_b_o, m_valid_o, m_sum_o, inflight_o, error_o
  );

  modport master (
    output s_valid_i, s_a_i, s_b_i, add_ack_i, add_res_valid_i, add_res_i, m_ready_i,
    input  s_ready_o, add_req_o, add_a_o, add_b_o, m_valid_o, m_sum_o, inflight_o, error_o
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fill count; head reads as zero while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign count_o = r_count;
  assign data_o  = empty_o ? '0 : r_mem[r_rd_ptr];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_pop  = pop_i && !empty_o;
  assign w_push = push_i && (!full_o || w_pop);

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/float_add_issuer.sv
// Buffers operand pairs, issues them to an in-order adder under a credit limit,
// and returns results in issue order.
module float_add_issuer
  import float_add_pkg::*;
#(
  parameter int unsigned DEPTH = FA_DEFAULT_DEPTH
) (
  input logic               clk_i,
  input logic               rst_i,
  float_add_issuer_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  operand_pair_t w_op_in;
  operand_pair_t w_op_head;
  logic          w_op_full;
  logic          w_op_empty;
  logic [CW-1:0] w_op_count;
  logic          w_op_push;

  logic [31:0]   w_res_head;
  logic          w_res_full;
  logic          w_res_empty;
  logic [CW-1:0] w_res_count;
  logic          w_res_pop;

  logic [CW-1:0] r_inflight;
  logic          r_error;
  logic          w_credit_ok;
  logic          w_req;
  logic          w_issue;
  logic          w_ret_ok;

  assign w_op_in   = {bus.s_a_i, bus.s_b_i};
  assign w_op_push = bus.s_valid_i && !w_op_full;

  // Credits left = DEPTH - inflight - res_count; any credit left permits an issue.
  assign w_credit_ok = ({1'b0, r_inflight} + {1'b0, w_res_count}) < (CW+1)'(DEPTH);
  assign w_req       = !w_op_empty && w_credit_ok;
  assign w_issue     = w_req && bus.add_ack_i;
  assign w_ret_ok    = bus.add_res_valid_i && (r_inflight != '0) && !w_res_full;
  assign w_res_pop   = !w_res_empty && bus.m_ready_i;

  sync_fifo #(
    .WIDTH($bits(operand_pair_t)),
    .DEPTH(DEPTH)
  ) u_op_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (w_op_push),
    .data_i (w_op_in),
    .pop_i  (w_issue),
    .data_o (w_op_head),
    .full_o (w_op_full),
    .empty_o(w_op_empty),
    .count_o(w_op_count)
  );

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(DEPTH)
  ) u_res_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .push_i (w_ret_ok),
    .data_i (bus.add_res_i),
    .pop_i  (w_res_pop),
    .data_o (w_res_head),
    .full_o (w_res_full),
    .empty_o(w_res_empty),
    .count_o(w_res_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_inflight <= '0;
      r_error    <= 1'b0;
    end else begin
      case ({w_issue, w_ret_ok})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
      if (bus.add_res_valid_i && !w_ret_ok) r_error <= 1'b1;
    end
  end

  assign bus.s_ready_o  = !w_op_full;
  assign bus.add_req_o  = w_req;
  assign bus.add_a_o    = w_op_head.a;
  assign bus.add_b_o    = w_op_head.b;
  assign bus.m_valid_o  = !w_res_empty;
  assign bus.m_sum_o    = w_res_head;
  assign bus.inflight_o = r_inflight;
  assign bus.error_o    = r_error;

endmodule

// File: tb/tb_float_add_issuer.sv
// Directed bench for float_add_issuer with a fixed-latency in-order adder stub.
module tb_float_add_issuer;
  import float_add_pkg::*;

  localparam int unsigned D   = 4;
  localparam int unsigned LAT = FA_PIPE_LATENCY;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spur = 1'b0;

  int pass_cnt  = 0;
  int total_cnt = 0;

  float_add_issuer_if #(.DEPTH(D)) bus ();

  float_add_issuer #(.DEPTH(D)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] stub_sum(input logic [31:0] a, input logic [31:0] b);
    case ({a, b})
      64'h3F800000_40000000: stub_sum = 32'h40400000;
      64'h40800000_40C00000: stub_sum = 32'h41200000;
      64'hC0000000_C0400000: stub_sum = 32'hC0A00000;
      64'h3F800000_BF800000: stub_sum = 32'h00000000;
      default:               stub_sum = a ^ b;
    endcase
  endfunction

  // Adder stub: fixed latency, shares the issuer reset.
  logic [LAT-1:0] pv;
  logic [31:0]    pd [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
      for (int i = 0; i < LAT; i++) pd[i] <= '0;
    end else begin
      pv[0] <= bus.add_req_o && bus.add_ack_i;
      pd[0] <= stub_sum(bus.add_a_o, bus.add_b_o);
      for (int i = 1; i < LAT; i++) begin
        pv[i] <= pv[i-1];
        pd[i] <= pd[i-1];
      end
    end
  end
  assign bus.add_res_valid_i = pv[LAT-1] | spur;
  assign bus.add_res_i       = pd[LAT-1];

  int          cyc = 0;
  int          issue_cnt = 0;
  logic [31:0] pop_q[$];
  int          pop_cyc[$];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && bus.add_req_o && bus.add_ack_i) issue_cnt <= issue_cnt + 1;
    if (!rst && bus.m_valid_o && bus.m_ready_i) begin
      pop_q.push_back(bus.m_sum_o);
      pop_cyc.push_back(cyc);
    end
  end

  task automatic test_reset();
    total_cnt++; if (bus.s_ready_o !== 1'b1) $display("FAIL reset_s_ready got %b want 1", bus.s_ready_o); else pass_cnt++;
    total_cnt++; if (bus.add_req_o !== 1'b0) $display("FAIL reset_add_req got %b want 0", bus.add_req_o); else pass_cnt++;
    total_cnt++; if (bus.m_valid_o !== 1'b0) $display("FAIL reset_m_valid got %b want 0", bus.m_valid_o); else pass_cnt++;
    total_cnt++; if (bus.inflight_o !== '0) $display("FAIL reset_inflight got %0d want 0", bus.inflight_o); else pass_cnt++;
    total_cnt++; if (bus.error_o !== 1'b0) $display("FAIL reset_error got %b want 0", bus.error_o); else pass_cnt++;
    total_cnt++; if ({bus.add_a_o, bus.add_b_o, bus.m_sum_o} !== 96'h0) $display("FAIL reset_data got %h want 0", {bus.add_a_o, bus.add_b_o, bus.m_sum_o}); else pass_cnt++;
  endtask

  task automatic test_single();
    int hit = 0;
    @(negedge clk);
    bus.add_ack_i = 1'b1; bus.m_ready_i = 1'b1;
    bus.s_a_i = 32'h3F800000; bus.s_b_i = 32'h40000000; bus.s_valid_i = 1'b1;
    #1;
    total_cnt++; if (bus.add_req_o !== 1'b0) $display("FAIL single_no_bypass got %b want 0", bus.add_req_o); else pass_cnt++;
    @(negedge clk);
    bus.s_valid_i = 1'b0;
    total_cnt++; if (bus.add_req_o !== 1'b1) $display("FAIL single_req got %b want 1", bus.add_req_o); else pass_cnt++;
    total_cnt++; if (bus.add_a_o !== 32'h3F800000) $display("FAIL single_add_a got %h want 3f800000", bus.add_a_o); else pass_cnt++;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 1) begin
        total_cnt++; if (bus.inflight_o !== 3'd1) $display("FAIL single_inflight1 got %0d want 1", bus.inflight_o); else pass_cnt++;
      end
      if (bus.m_valid_o === 1'b1) begin hit = i; break; end
    end
    total_cnt++; if (hit != 6) $display("FAIL single_latency got %0d want 6", hit); else pass_cnt++;
    total_cnt++; if (bus.m_sum_o !== 32'h40400000) $display("FAIL single_sum got %h want 40400000", bus.m_sum_o); else pass_cnt++;
    total_cnt++; if (bus.inflight_o !== '0) $display("FAIL single_inflight0 got %0d want 0", bus.inflight_o); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (bus.m_valid_o !== 1'b0) $display("FAIL single_one_cycle got %b want 0", bus.m_valid_o); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int k = 0;
    int ib = issue_cnt;
    int pb = pop_q.size();
    logic [31:0] exp_v;
    bus.m_ready_i = 1'b0; bus.add_ack_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (k < 10) begin
        bus.s_a_i = 32'h10000000 + 32'(k); bus.s_b_i = 32'(k) << 8; bus.s_valid_i = 1'b1;
      end else bus.s_valid_i = 1'b0;
      if (bus.s_valid_i && bus.s_ready_o) k++;
    end
    total_cnt++; if (k != 8) $display("FAIL bp_accepted got %0d want 8", k); else pass_cnt++;
    total_cnt++; if (bus.s_ready_o !== 1'b0) $display("FAIL bp_s_ready got %b want 0", bus.s_ready_o); else pass_cnt++;
    total_cnt++; if (issue_cnt - ib != 4) $display("FAIL bp_issues got %0d want 4", issue_cnt - ib); else pass_cnt++;
    total_cnt++; if (bus.add_req_o !== 1'b0) $display("FAIL bp_add_req got %b want 0", bus.add_req_o); else pass_cnt++;
    total_cnt++; if (bus.m_sum_o !== 32'h10000000) $display("FAIL bp_head got %h want 10000000", bus.m_sum_o); else pass_cnt++;
    bus.m_ready_i = 1'b1;
    for (int c = 0; c < 200 && (pop_q.size() - pb) < 10; c++) begin
      @(negedge clk);
      if (k < 10) begin
        bus.s_a_i = 32'h10000000 + 32'(k); bus.s_b_i = 32'(k) << 8; bus.s_valid_i = 1'b1;
      end else bus.s_valid_i = 1'b0;
      if (bus.s_valid_i && bus.s_ready_o) k++;
    end
    bus.s_valid_i = 1'b0;
    total_cnt++; if (pop_q.size() - pb != 10) $display("FAIL bp_drain_count got %0d want 10", pop_q.size() - pb); else pass_cnt++;
    for (int j = 0; j < 10 && pb + j < pop_q.size(); j++) begin
      exp_v = (32'h10000000 + 32'(j)) ^ (32'(j) << 8);
      total_cnt++; if (pop_q[pb+j] !== exp_v) $display("FAIL bp_order[%0d] got %h want %h", j, pop_q[pb+j], exp_v); else pass_cnt++;
    end
  endtask

  task automatic test_issue_stall();
    int ib;
    int pb = pop_q.size();
    bus.add_ack_i = 1'b0; bus.m_ready_i = 1'b1;
    @(negedge clk);
    bus.s_a_i = 32'h11111111; bus.s_b_i = 32'h22222222; bus.s_valid_i = 1'b1;
    @(negedge clk);
    bus.s_a_i = 32'hAAAA0000; bus.s_b_i = 32'h0000AAAA;
    @(negedge clk);
    bus.s_valid_i = 1'b0;
    ib = issue_cnt;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total_cnt++;
      if ({bus.add_req_o, bus.add_a_o, bus.add_b_o} !== {1'b1, 32'h11111111, 32'h22222222})
        $display("FAIL stall_hold[%0d] got %b %h %h want 1 11111111 22222222", c, bus.add_req_o, bus.add_a_o, bus.add_b_o);
      else pass_cnt++;
    end
    bus.add_ack_i = 1'b1;
    @(negedge clk);
    bus.add_ack_i = 1'b0;
    total_cnt++; if (issue_cnt - ib != 1) $display("FAIL stall_one_pop got %0d want 1", issue_cnt - ib); else pass_cnt++;
    total_cnt++; if (bus.add_a_o !== 32'hAAAA0000) $display("FAIL stall_next_head got %h want aaaa0000", bus.add_a_o); else pass_cnt++;
    bus.add_ack_i = 1'b1;
    for (int c = 0; c < 40 && (pop_q.size() - pb) < 2; c++) @(negedge clk);
    total_cnt++; if (pop_q.size() - pb != 2) $display("FAIL stall_drain got %0d want 2", pop_q.size() - pb); else pass_cnt++;
    if (pop_q.size() - pb >= 2) begin
      total_cnt++; if ({pop_q[pb], pop_q[pb+1]} !== {32'h33333333, 32'hAAAAAAAA}) $display("FAIL stall_sums got %h %h want 33333333 aaaaaaaa", pop_q[pb], pop_q[pb+1]); else pass_cnt++;
    end
  endtask

  task automatic test_ordering();
    logic [31:0] av [3];
    logic [31:0] bv [3];
    logic [31:0] sv [3];
    int pb = pop_q.size();
    av[0] = 32'h40800000; bv[0] = 32'h40C00000; sv[0] = 32'h41200000;
    av[1] = 32'hC0000000; bv[1] = 32'hC0400000; sv[1] = 32'hC0A00000;
    av[2] = 32'h3F800000; bv[2] = 32'hBF800000; sv[2] = 32'h00000000;
    bus.add_ack_i = 1'b1; bus.m_ready_i = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      bus.s_a_i = av[j]; bus.s_b_i = bv[j]; bus.s_valid_i = 1'b1;
    end
    @(negedge clk);
    bus.s_valid_i = 1'b0;
    for (int c = 0; c < 40 && (pop_q.size() - pb) < 3; c++) @(negedge clk);
    total_cnt++; if (pop_q.size() - pb != 3) $display("FAIL order_count got %0d want 3", pop_q.size() - pb); else pass_cnt++;
    for (int j = 0; j < 3 && pb + j < pop_q.size(); j++) begin
      total_cnt++; if (pop_q[pb+j] !== sv[j]) $display("FAIL order_sum[%0d] got %h want %h", j, pop_q[pb+j], sv[j]); else pass_cnt++;
      if (j > 0) begin
        total_cnt++; if (pop_cyc[pb+j] != pop_cyc[pb+j-1] + 1) $display("FAIL order_bubble[%0d] got gap %0d want 1", j, pop_cyc[pb+j] - pop_cyc[pb+j-1]); else pass_cnt++;
      end
    end
    total_cnt++; if (bus.error_o !== 1'b0) $display("FAIL order_error got %b want 0", bus.error_o); else pass_cnt++;
  endtask

  task automatic test_spurious();
    @(negedge clk);
    total_cnt++; if (bus.inflight_o !== '0) $display("FAIL spur_idle got %0d want 0", bus.inflight_o); else pass_cnt++;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    total_cnt++; if (bus.error_o !== 1'b1) $display("FAIL spur_error got %b want 1", bus.error_o); else pass_cnt++;
    total_cnt++; if (bus.m_valid_o !== 1'b0) $display("FAIL spur_m_valid got %b want 0", bus.m_valid_o); else pass_cnt++;
    repeat (3) @(negedge clk);
    total_cnt++; if (bus.error_o !== 1'b1) $display("FAIL spur_sticky got %b want 1", bus.error_o); else pass_cnt++;
  endtask

  task automatic test_reset_midflight();
    int hit = 0;
    bus.add_ack_i = 1'b1; bus.m_ready_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      bus.s_a_i = 32'h50000000 + 32'(j); bus.s_b_i = 32'h00000077; bus.s_valid_i = 1'b1;
    end
    @(negedge clk);
    bus.s_valid_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.inflight_o === 3'd3) begin hit = 1; break; end
      @(negedge clk);
    end
    total_cnt++; if (hit != 1) $display("FAIL rstmid_inflight3 got %0d want 3", bus.inflight_o); else pass_cnt++;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total_cnt++; if ({bus.s_ready_o, bus.add_req_o, bus.m_valid_o, bus.error_o} !== 4'b1000)
      $display("FAIL rstmid_flags got %b want 1000", {bus.s_ready_o, bus.add_req_o, bus.m_valid_o, bus.error_o}); else pass_cnt++;
    total_cnt++; if (bus.inflight_o !== '0) $display("FAIL rstmid_inflight got %0d want 0", bus.inflight_o); else pass_cnt++;
    total_cnt++; if ({bus.add_a_o, bus.m_sum_o} !== 64'h0) $display("FAIL rstmid_data got %h want 0", {bus.add_a_o, bus.m_sum_o}); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bus.s_valid_i = 1'b0; bus.s_a_i = '0; bus.s_b_i = '0;
    bus.add_ack_i = 1'b0; bus.m_ready_i = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_single();
    test_back_to_back();
    test_issue_stall();
    test_ordering();
    test_spurious();
    test_reset_midflight();
    test_single();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
